// File: rtl/lsu_pkg.sv
// Shared encodings for the data-memory load/store unit.
// Size codes and FSM state encoding.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_lsu_if.sv
// Datapath request/response handshake plus DMEM port bundle.
// slave: LSU side; master: datapath + DMEM side.
interface dmem_lsu_if #(
  parameter int MEM_AW = 8
);
  logic              LSU_req_valid;
  logic              LSU_req_ready;
  logic              LSU_req_we;
  logic [1:0]        LSU_req_size;
  logic              LSU_req_unsigned;
  logic [31:0]       LSU_req_addr;
  logic [31:0]       LSU_req_wdata;
  logic              LSU_rsp_valid;
  logic [31:0]       LSU_rsp_rdata;
  logic              LSU_rsp_err;
  logic [MEM_AW-1:0] LSU_mem_address;
  logic [31:0]       LSU_mem_data_out;
  logic              LSU_mem_write;
  logic              LSU_mem_read;
  logic [31:0]       LSU_mem_data_in;

  modport slave (
    input  LSU_req_valid, LSU_req_we,
    input  LSU_req_size, LSU_req_unsigned,
    input  LSU_req_addr, LSU_req_wdata,
    input  LSU_mem_data_in,
    output LSU_req_ready,
    output LSU_rsp_valid, LSU_rsp_rdata,
    output LSU_rsp_err,
    output LSU_mem_address, LSU_mem_data_out,
    output LSU_mem_write, LSU_mem_read
  );

  modport master (
    output LSU_req_valid, LSU_req_we,
    output LSU_req_size, LSU_req_unsigned,
    output LSU_req_addr, LSU_req_wdata,
    output LSU_mem_data_in,
    input  LSU_req_ready,
    input  LSU_rsp_valid, LSU_rsp_rdata,
    input  LSU_rsp_err,
    input  LSU_mem_address, LSU_mem_data_out,
    input  LSU_mem_write, LSU_mem_read
  );
endinterface

// File: rtl/lsu_lane_merge.sv
// Big-endian lane logic: store merge and load extract/extend.
// In: word, wdata, size, off, uns. Out: merged, rdata.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Offset 0 is the most significant lane.
  assign bsh    = {~off_i, 3'b000};
  assign hsh    = {~off_i[1], 4'b0000};
  assign byte_v = word_i[bsh +: 8];
  assign half_v = word_i[hsh +: 16];

  always_comb begin
    merged_o = wdata_i;
    rdata_o  = word_i;
    unique case (1'b1)
      size_i == SZ_BYTE: begin
        merged_o = (word_i & ~(32'h0000_00ff << bsh))
                 | ({24'h0, wdata_i[7:0]} << bsh);
        rdata_o  = uns_i ? {24'h0, byte_v}
                         : {{24{byte_v[7]}}, byte_v};
      end
      size_i == SZ_HALF: begin
        merged_o = (word_i & ~(32'h0000_ffff << hsh))
                 | ({16'h0, wdata_i[15:0]} << hsh);
        rdata_o  = uns_i ? {16'h0, half_v}
                         : {{16{half_v[15]}}, half_v};
      end
      default: begin
        merged_o = wdata_i;
        rdata_o  = word_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide DMEM; sub-word stores use RMW.
// Ports: LSU_clk, LSU_rst_n, bus (dmem_lsu_if.slave). Option: LSU_ALIGN_CHECK_EN.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int MEM_AW    = 8,
  parameter int MEM_WORDS = 11
) (
  input logic       LSU_clk,
  input logic       LSU_rst_n,
  dmem_lsu_if.slave bus
);

  localparam logic [MEM_AW-1:0] LIM = MEM_AW'(MEM_WORDS);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;

  logic        accept;
  logic        range_err;
  logic        misalign;
  logic        req_err;
  logic [31:0] merged;
  logic [31:0] ext;

  assign accept = bus.LSU_req_valid && (state_q == IDLE);

  // Any address bit above the DMEM window is also out of range.
  assign range_err =
    (bus.LSU_req_addr[31:MEM_AW+2] != '0) ||
    (bus.LSU_req_addr[MEM_AW+1:2] >= LIM);

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign =
    ((bus.LSU_req_size == SZ_HALF) && bus.LSU_req_addr[0]) ||
    ((bus.LSU_req_size == SZ_WORD) &&
     (bus.LSU_req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (bus.LSU_req_size == 2'b11) || range_err || misalign;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    size_d  = size_q;
    off_d   = off_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = bus.LSU_req_we;
          uns_d   = bus.LSU_req_unsigned;
          size_d  = bus.LSU_req_size;
          off_d   = bus.LSU_req_addr[1:0];
          idx_d   = bus.LSU_req_addr[MEM_AW+1:2];
          wdata_d = bus.LSU_req_wdata;
          err_d   = req_err;
          if (req_err)
            state_d = RESP;
          else if (bus.LSU_req_we && bus.LSU_req_size == SZ_WORD)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        word_d  = bus.LSU_mem_data_in;
        state_d = we_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge LSU_clk or negedge LSU_rst_n) begin
    if (!LSU_rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
    end
  end

  lsu_lane_merge u_lane (
    .word_i   (word_q),
    .wdata_i  (wdata_q),
    .size_i   (size_q),
    .off_i    (off_q),
    .uns_i    (uns_q),
    .merged_o (merged),
    .rdata_o  (ext)
  );

  assign bus.LSU_req_ready    = (state_q == IDLE);
  assign bus.LSU_rsp_valid    = (state_q == RESP);
  assign bus.LSU_rsp_err      = (state_q == RESP) && err_q;
  assign bus.LSU_rsp_rdata    =
    ((state_q == RESP) && !we_q && !err_q) ? ext : '0;
  assign bus.LSU_mem_read     = (state_q == RD);
  assign bus.LSU_mem_write    = (state_q == WR);
  assign bus.LSU_mem_address  = idx_q;
  assign bus.LSU_mem_data_out =
    (size_q == SZ_WORD) ? wdata_q : merged;

endmodule
